// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM output stages.
package pwm_pkg;

  typedef enum logic [2:0] {
    OFF,
    DEAD_H,
    HIGH,
    DEAD_L,
    LOW,
    TRIP
  } pwm_dt_state_t;

  localparam int DT_W_DEFAULT = 8;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time, enable gating
// and a latched trip-zone shutdown. Runs in the same clock domain as its PWM source.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            PWM_i,
  input  logic            enable_i,
  input  logic            trip_i,
  input  logic            clear_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic            PWM_H_o,
  output logic            PWM_L_o,
  output logic            fault_o,
  output logic            active_o
);

  pwm_dt_state_t   state;
  pwm_dt_state_t   next_state;
  logic [DT_W-1:0] dt_cnt;
  logic            load_cnt;
  logic            in_dead;
  logic            pwm_h_q;
  logic            pwm_l_q;
  logic            fault_q;
  logic            active_q;

  assign in_dead = (state == DEAD_H) || (state == DEAD_L);

  // A DEAD state whose counter hits zero commits to its target before the abort check.
  always_comb begin
    next_state = state;
    if (trip_i) begin
      next_state = TRIP;
    end else if (state == TRIP) begin
      if (clear_i) next_state = OFF;
    end else if (!enable_i) begin
      next_state = OFF;
    end else begin
      case (state)
        OFF:     next_state = PWM_i ? DEAD_H : DEAD_L;
        LOW:     if (PWM_i)  next_state = DEAD_H;
        HIGH:    if (!PWM_i) next_state = DEAD_L;
        DEAD_H: begin
          if (dt_cnt == '0)  next_state = HIGH;
          else if (!PWM_i)   next_state = LOW;
        end
        DEAD_L: begin
          if (dt_cnt == '0)  next_state = LOW;
          else if (PWM_i)    next_state = HIGH;
        end
        default: next_state = OFF;
      endcase
    end
  end

  assign load_cnt = ((next_state == DEAD_H) || (next_state == DEAD_L)) &&
                    (next_state != state);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= OFF;
      dt_cnt <= '0;
    end else begin
      state <= next_state;
      if (load_cnt)
        dt_cnt <= deadtime_i;
      else if (in_dead && (dt_cnt != '0))
        dt_cnt <= dt_cnt - 1'b1;
    end
  end

  // Outputs are decoded from next_state into flops so every gate pin comes straight off a register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwm_h_q  <= 1'b0;
      pwm_l_q  <= 1'b0;
      fault_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      pwm_h_q  <= (next_state == HIGH);
      pwm_l_q  <= (next_state == LOW);
      fault_q  <= (next_state == TRIP);
      active_q <= (next_state == DEAD_H) || (next_state == HIGH) ||
                  (next_state == DEAD_L) || (next_state == LOW);
    end
  end

  assign PWM_H_o  = pwm_h_q;
  assign PWM_L_o  = pwm_l_q;
  assign fault_o  = fault_q;
  assign active_o = active_q;

endmodule
